// File: rtl/chop_mult_sequencer_pkg.sv
// Shared types and defaults for the chopped multiply sequencer.
// Holds the FSM state encoding and the per-chop sign rule.
package chop_mult_sequencer_pkg;

    localparam int CHOP_SIZE_DEFAULT = 8;
    localparam int N_CHOPS_DEFAULT   = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Only the most significant chop of a signed operand carries the sign;
    // in half mode the single low chop stands for the whole operand.
    function automatic logic chop_sign(input int idx, input int n_chops,
                                       input logic op_sign, input logic half);
        logic s;
        if (half) begin
            s = op_sign;
        end else begin
            s = op_sign && (idx == n_chops - 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/chop_mult_sequencer_if.sv
// Operand-source and result-sink handshake bundle for the chopped multiply
// sequencer.
interface chop_mult_sequencer_if
    import chop_mult_sequencer_pkg::*;
#(
    parameter int W = CHOP_SIZE_DEFAULT * N_CHOPS_DEFAULT
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           A_sign;
    logic           B_sign;
    logic           HALF_0;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] C;

    modport master (
        output in_valid, A, B, A_sign, B_sign, HALF_0, out_ready,
        input  in_ready, out_valid, C
    );

    modport slave (
        input  in_valid, A, B, A_sign, B_sign, HALF_0, out_ready,
        output in_ready, out_valid, C
    );
endinterface

// File: rtl/chop_mult_sequencer_mult.sv
// One sign-configurable CHOP_SIZE x CHOP_SIZE multiplier chop (chop_mult_sc).
// Purely combinational; the sequencer time-shares a single instance.
module chop_mult_sc
    import chop_mult_sequencer_pkg::*;
#(
    parameter int CHOP_SIZE = CHOP_SIZE_DEFAULT
) (
    input  logic [CHOP_SIZE-1:0]   a,
    input  logic [CHOP_SIZE-1:0]   b,
    input  logic                   a_sign,
    input  logic                   b_sign,
    output logic [2*CHOP_SIZE-1:0] p
);
    logic signed [2*CHOP_SIZE-1:0] a_ext;
    logic signed [2*CHOP_SIZE-1:0] b_ext;

    // Any signed/unsigned chop product fits in 2*CHOP_SIZE bits, so a
    // truncated signed multiply of the extended operands is exact.
    always_comb begin
        a_ext = {{CHOP_SIZE{a_sign & a[CHOP_SIZE-1]}}, a};
        b_ext = {{CHOP_SIZE{b_sign & b[CHOP_SIZE-1]}}, b};
        p     = a_ext * b_ext;
    end
endmodule

// File: rtl/chop_mult_sequencer.sv
// Multi-cycle full-width multiplier: one chop partial product per cycle,
// shifted and accumulated into a 2*W result, with a single-step half mode.
module chop_mult_sequencer
    import chop_mult_sequencer_pkg::*;
#(
    parameter int CHOP_SIZE = CHOP_SIZE_DEFAULT,
    parameter int N_CHOPS   = N_CHOPS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    chop_mult_sequencer_if.slave  bus,
    output logic                  busy
);
    localparam int W      = CHOP_SIZE * N_CHOPS;
    localparam int ACC_W  = 2 * W;
    localparam int PP_W   = 2 * CHOP_SIZE;
    localparam int STEPS  = N_CHOPS * N_CHOPS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t              state;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic                a_sign_reg;
    logic                b_sign_reg;
    logic                half_reg;
    logic [STEP_W-1:0]   step;
    logic [ACC_W-1:0]    acc;

    int                  ia;
    int                  ib;
    logic [CHOP_SIZE-1:0] a_chop;
    logic [CHOP_SIZE-1:0] b_chop;
    logic                sa;
    logic                sb;
    logic                last_step;
    logic [PP_W-1:0]     pp;
    logic [ACC_W-1:0]    pp_ext;
    logic [ACC_W-1:0]    acc_next;

    always_comb begin
        ia        = int'(step) % N_CHOPS;
        ib        = int'(step) / N_CHOPS;
        a_chop    = a_reg[ia*CHOP_SIZE +: CHOP_SIZE];
        b_chop    = b_reg[ib*CHOP_SIZE +: CHOP_SIZE];
        sa        = chop_sign(ia, N_CHOPS, a_sign_reg, half_reg);
        sb        = chop_sign(ib, N_CHOPS, b_sign_reg, half_reg);
        last_step = half_reg || (step == STEP_W'(STEPS - 1));
    end

    chop_mult_sc #(.CHOP_SIZE(CHOP_SIZE)) u_chop (
        .a      (a_chop),
        .b      (b_chop),
        .a_sign (sa),
        .b_sign (sb),
        .p      (pp)
    );

    // A partial product is negative only if one of its chops was signed.
    always_comb begin
        pp_ext   = {{(ACC_W-PP_W){(sa | sb) & pp[PP_W-1]}}, pp};
        acc_next = acc + (pp_ext << (CHOP_SIZE * (ia + ib)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            step          <= '0;
            acc           <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            a_sign_reg    <= 1'b0;
            b_sign_reg    <= 1'b0;
            half_reg      <= 1'b0;
            bus.C         <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg        <= bus.A;
                        b_reg        <= bus.B;
                        a_sign_reg   <= bus.A_sign;
                        b_sign_reg   <= bus.B_sign;
                        half_reg     <= bus.HALF_0;
                        acc          <= '0;
                        step         <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    step <= step + STEP_W'(1);
                    if (last_step) begin
                        bus.C         <= acc_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the next accept is a cycle later.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chop_mult_sequencer.sv
// Self-checking bench for chop_mult_sequencer: directed vectors with literal
// results plus a product model checked every cycle the result is presented.
module tb_chop_mult_sequencer;
    import chop_mult_sequencer_pkg::*;

    localparam int CS = 8;
    localparam int NC = 2;
    localparam int W  = CS * NC;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    chop_mult_sequencer_if #(.W(W)) bus ();

    chop_mult_sequencer #(.CHOP_SIZE(CS), .N_CHOPS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [2*W-1:0] exp_c = '0;

    // Product of the operands as integers, reduced to 2*W bits; half mode
    // keeps only the low chop of each operand, extended per its sign.
    function automatic logic [2*W-1:0] modelProduct(input logic [W-1:0] a, input logic [W-1:0] b,
                                                    input logic as, input logic bs, input logic half);
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        longint va;
        longint vb;
        longint p;
        ma = a;
        mb = b;
        if (half) begin
            ma = {{(W-CS){as & a[CS-1]}}, a[CS-1:0]};
            mb = {{(W-CS){bs & b[CS-1]}}, b[CS-1:0]};
        end
        va = as ? longint'($signed(ma)) : longint'(ma);
        vb = bs ? longint'($signed(mb)) : longint'(mb);
        p  = va * vb;
        return p[2*W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            checkOutput("C_vs_model", bus.C, exp_c);
            checkOutput("in_ready_in_done", bus.in_ready, 0);
            checkOutput("busy_in_done", busy, 1);
        end else if (!reset && busy) begin
            checkOutput("in_ready_in_run", bus.in_ready, 0);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic as, input logic bs, input logic half,
                                 input logic check_lit, input logic [2*W-1:0] lit, input int hold);
        int n;
        int exp_lat;
        exp_lat = half ? 1 : NC * NC;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) checkOutput("in_ready_timeout", bus.in_ready, 1);
        bus.A        = a;
        bus.B        = b;
        bus.A_sign   = as;
        bus.B_sign   = bs;
        bus.HALF_0   = half;
        bus.in_valid = 1'b1;
        exp_c        = modelProduct(a, b, as, bs, half);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A        = W'($urandom);
        bus.B        = W'($urandom);
        bus.A_sign   = ~as;
        bus.B_sign   = ~bs;
        bus.HALF_0   = ~half;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", n, exp_lat);
        if (check_lit) checkOutput("C_literal", bus.C, lit);
        repeat (hold) begin
            @(posedge clk); #1;
            checkOutput("out_valid_stall", bus.out_valid, 1);
            checkOutput("in_ready_stall", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("out_valid_cleared", bus.out_valid, 0);
        checkOutput("in_ready_restored", bus.in_ready, 1);
        checkOutput("busy_cleared", busy, 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.A_sign    = 1'b0;
        bus.B_sign    = 1'b0;
        bus.HALF_0    = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_C", bus.C, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle with no request must stay idle.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_busy", busy, 0);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFE0001, 0);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40000000, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF0001, 0);
        applyStimulus(16'h1280, 16'h347F, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFC080, 0);
        applyStimulus(16'h1280, 16'h347F, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00003F80, 10);

        // Abort an operation at step 2 with an asynchronous reset.
        bus.A        = 16'h7FFF;
        bus.B        = 16'h7FFF;
        bus.A_sign   = 1'b1;
        bus.B_sign   = 1'b1;
        bus.HALF_0   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_C", bus.C, 0);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_in_ready", bus.in_ready, 1);
        checkOutput("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_result", bus.out_valid, 0);
        applyStimulus(16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000000F, 0);

        for (int combo = 0; combo < 8; combo++) begin
            for (int i = 0; i < 300; i++) begin
                applyStimulus(W'($urandom), W'($urandom), combo[0], combo[1], combo[2],
                              1'b0, '0, int'($urandom_range(0, 2)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
